uart_wishbone_host: RTL
=======================

Name: uart_wishbone_host

Overview:
- Host-side end of the UART Wishbone bridge link. Turns one parallel request (we, 23-bit address, 8-bit data) into the bridge's 4-byte UART command frame.
- Then receives the single response byte from the bridge and returns it, with timeout and framing-error status.
- Used by on-chip test controllers and by the verification environment to drive the bridge over its serial pins.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Must be even and >= 4; 16 matches the bridge.
- TIMEOUT_CLKS, 4096, cycles allowed from receiver arming until the response start bit is confirmed.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  23  target address
- req_dat_i  in  8  write data (sent for reads too)
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_dat_o  out  8  response byte
- rsp_timeout_o  out  1  completion was a timeout
- rsp_frame_err_o  out  1  response stop bit sampled low
- uart_txd  out  1  serial out to the bridge's uart_rxd
- uart_rxd  in  1  serial in from the bridge's uart_txd

Behaviour:
- Reset (async, rst_ni low):
  - uart_txd = 1, req_ready_o = 1, rsp_valid_o = 0.
  - rsp_dat_o = 0x00, rsp_timeout_o = 0, rsp_frame_err_o = 0.
  - State = IDLE; all counters cleared.
  - Asserting reset mid-frame forces uart_txd high immediately. No completion pulse is produced for the aborted request.
- uart_rxd passes through a 2-flop synchronizer (reset value 1). All receive logic uses the synchronized value.
- Handshake:
  - A request is accepted on a cycle with req_valid_i && req_ready_o.
  - we, adr and dat are latched into a 32-bit shift register; req_ready_o drops on the next cycle.
  - req_valid_i is ignored while not in IDLE.
- Frame byte order: B0 = {we, adr[22:16]}, B1 = adr[15:8], B2 = adr[7:0], B3 = dat.
- Byte format: start bit 0, 8 data bits LSB first, one stop bit 1. No gap between bytes.
- Bit timing: every bit holds uart_txd for exactly CLKS_PER_BIT cycles. The start bit of B0 appears on the cycle after acceptance. The whole transmit phase is 40*CLKS_PER_BIT cycles.
- States: IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP.
  - IDLE -> TX_START on acceptance.
  - TX_START -> TX_DATA.
  - TX_DATA -> TX_STOP after the 8th bit.
  - TX_STOP -> TX_START while the byte counter < 3.
  - Receiver arming: the receiver is armed (timeout counter cleared) on the first cycle of B3's stop bit, because the bridge can start replying before that bit ends.
  - While B3's stop bit is still driven, a falling edge on rxd is tracked in parallel. The state then follows the receive path and uart_txd stays 1.
  - RX_WAIT: a synchronized 1->0 transition -> RX_START.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then sample. Low -> RX_DATA; high -> RX_WAIT (glitch rejected, timeout keeps counting).
  - RX_DATA: sample every CLKS_PER_BIT cycles and shift in LSB first. After 8 bits -> RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT cycles. Set rsp_dat_o to the received byte and rsp_frame_err_o = ~sample; pulse rsp_valid_o; -> IDLE.
- Timeout:
  - The counter runs in RX_WAIT and RX_START only.
  - Reaching TIMEOUT_CLKS with no confirmed start bit completes the request with rsp_timeout_o = 1, rsp_dat_o = 0x00, rsp_frame_err_o = 0, and a rsp_valid_o pulse; -> IDLE.
  - A start confirmed on the same cycle as expiry takes priority over the timeout.
- Completion outputs:
  - rsp_dat_o and the flags hold until the next completion.
  - rsp_valid_o is high exactly one cycle.
  - req_ready_o returns high on the cycle after the rsp_valid_o pulse.

Test Plan:
- Write: we=1, adr=0x412345, dat=0xA5 -> txd bytes 0xC1, 0x23, 0x45, 0xA5, each bit exactly 16 clocks. A model replies 0x00 -> rsp_valid_o pulse, rsp_dat_o = 0x00, both flags 0.
- Read: we=0, adr=0x000010 -> bytes 0x00, 0x00, 0x10, dat. The model replies 0x5A starting 8 clocks into B3's stop bit -> rsp_dat_o = 0x5A, no errors.
- Timeout: no reply -> rsp_valid_o with rsp_timeout_o = 1 exactly TIMEOUT_CLKS cycles after arming; req_ready_o = 1 the next cycle.
- Glitch plus framing:
  - A 3-cycle low pulse on rxd in RX_WAIT -> ignored.
  - A following real byte 0x81 with a low stop bit -> rsp_dat_o = 0x81, rsp_frame_err_o = 1.
- Busy/back-to-back:
  - req_valid_i held through a transaction -> exactly one request accepted per completion.
  - A second request's start bit is on the cycle after req_ready_o rises.
- Reset mid-frame: rst_ni low during B1 -> uart_txd = 1 asynchronously, no rsp_valid_o. After release, a new request transmits a correct full frame.

Source files
------------

// File: rtl/uart_wishbone_host.sv
// uart_wishbone_host: sends one request as the bridge's 4-byte UART frame, then collects the 1-byte reply.
// Latency: start bit on the cycle after acceptance, 40 bit-times of transmit, then reply or TIMEOUT_CLKS.
// Backpressure: req_ready_o is low from acceptance through the completion pulse; requests are not queued.
// Ports: clk_i / rst_ni       clock, asynchronous active-low reset
//        req_*                request handshake (valid/ready) and payload (we, 23-bit adr, 8-bit dat)
//        rsp_*                one-cycle completion pulse, response byte, timeout and framing-error flags
//        uart_txd / uart_rxd  serial link to the bridge (idle high)
module uart_wishbone_host #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [22:0] req_adr_i,
  input  logic [7:0]  req_dat_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_dat_o,
  output logic        rsp_timeout_o,
  output logic        rsp_frame_err_o,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TX_START = 3'd1;
  localparam logic [2:0] S_TX_DATA  = 3'd2;
  localparam logic [2:0] S_TX_STOP  = 3'd3;
  localparam logic [2:0] S_RX_WAIT  = 3'd4;
  localparam logic [2:0] S_RX_START = 3'd5;
  localparam logic [2:0] S_RX_DATA  = 3'd6;
  localparam logic [2:0] S_RX_STOP  = 3'd7;

  logic [2:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [1:0]    r_byte_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [31:0]   r_tx_shift;
  logic [7:0]    r_rx_shift;
  logic          r_txd;
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_d;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_dat;
  logic          r_rsp_timeout;
  logic          r_rsp_frame_err;

  logic w_accept;
  logic w_bit_end;
  logic w_half_bit;
  logic w_to_expired;
  logic w_rx_fall;

  // Ready stays low during the completion pulse so a held req_valid_i is
  // taken exactly once per completion.
  assign req_ready_o  = (r_state == S_IDLE) && !r_rsp_valid;
  assign w_accept     = req_valid_i && req_ready_o;
  assign w_bit_end    = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_half_bit   = (r_clk_cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign w_to_expired = (r_to_cnt == TW'(TIMEOUT_CLKS - 1));
  assign w_rx_fall    = r_rx_d && !r_rx_s2;

  assign uart_txd        = r_txd;
  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_dat_o       = r_rsp_dat;
  assign rsp_timeout_o   = r_rsp_timeout;
  assign rsp_frame_err_o = r_rsp_frame_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= S_IDLE;
      r_clk_cnt       <= '0;
      r_bit_cnt       <= '0;
      r_byte_cnt      <= '0;
      r_to_cnt        <= '0;
      r_tx_shift      <= '0;
      r_rx_shift      <= '0;
      r_txd           <= 1'b1;
      r_rx_s1         <= 1'b1;
      r_rx_s2         <= 1'b1;
      r_rx_d          <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_rsp_dat       <= '0;
      r_rsp_timeout   <= 1'b0;
      r_rsp_frame_err <= 1'b0;
    end else begin
      r_rx_s1     <= uart_rxd;
      r_rx_s2     <= r_rx_s1;
      r_rx_d      <= r_rx_s2;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Byte 0 sits in the low byte so the whole frame leaves by shifting right.
            r_tx_shift <= {req_dat_i, req_adr_i[7:0], req_adr_i[15:8], req_we_i, req_adr_i[22:16]};
            r_txd      <= 1'b0;
            r_clk_cnt  <= '0;
            r_byte_cnt <= '0;
            r_state    <= S_TX_START;
          end
        end
        S_TX_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_txd     <= r_tx_shift[0];
            r_state   <= S_TX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_TX_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt  <= '0;
            r_tx_shift <= {1'b0, r_tx_shift[31:1]};
            if (r_bit_cnt == 3'd7) begin
              r_txd <= 1'b1;
              // The last stop bit is just idle-high line: the receiver is armed
              // on its first cycle since the bridge may answer before it ends.
              if (r_byte_cnt == 2'd3) begin
                r_to_cnt <= '0;
                r_state  <= S_RX_WAIT;
              end else begin
                r_state  <= S_TX_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_tx_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_TX_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt  <= '0;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_txd      <= 1'b0;
            r_state    <= S_TX_START;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_RX_WAIT: begin
          if (w_to_expired) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_dat       <= '0;
            r_rsp_timeout   <= 1'b1;
            r_rsp_frame_err <= 1'b0;
            r_state         <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
            if (w_rx_fall) begin
              r_clk_cnt <= '0;
              r_state   <= S_RX_START;
            end
          end
        end
        S_RX_START: begin
          // A confirmed start bit wins over a timeout expiring on the same cycle.
          if (w_half_bit && !r_rx_s2) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_RX_DATA;
          end else if (w_to_expired) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_dat       <= '0;
            r_rsp_timeout   <= 1'b1;
            r_rsp_frame_err <= 1'b0;
            r_state         <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
            if (w_half_bit) begin
              r_state <= S_RX_WAIT;
            end else begin
              r_clk_cnt <= r_clk_cnt + CW'(1);
            end
          end
        end
        S_RX_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt  <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_RX_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_RX_STOP: begin
          if (w_bit_end) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_dat       <= r_rx_shift;
            r_rsp_timeout   <= 1'b0;
            r_rsp_frame_err <= !r_rx_s2;
            r_clk_cnt       <= '0;
            r_state         <= S_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
